// File: rtl/convertidor_param.sv
// convertidor_param: packs DATA_W-bit symbols into words of 2^MODE symbols (max LANES).
// Latency: one cycle from the last accepted symbol to out_valid; one symbol per cycle.
// Backpressure: a held output word (out_valid && !out_ready) stalls in_ready; partial word kept.
// Optional feature macro: CONV_FLUSH_EN adds the flush input and out_count output.
module convertidor_param #(
  parameter int DATA_W = 8,
  parameter int LANES  = 4
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        ENB,
  input  logic [$clog2(LANES):0]      MODE,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  output logic                        in_ready,
  output logic                        out_valid,
  output logic [DATA_W*LANES-1:0]     out_data,
  input  logic                        out_ready
`ifdef CONV_FLUSH_EN
  ,
  input  logic                        flush,
  output logic [$clog2(LANES):0]      out_count
`endif
);

  localparam int OUT_W = DATA_W * LANES;
  localparam int LG    = $clog2(LANES);
  localparam int MW    = LG + 1;

  // Word assembly state. The partial register is a left-shifting accumulator, so
  // the first symbol naturally ends up in the most significant occupied lane and
  // any word (full or flushed) is already right-justified with zero upper bits.
  logic [MW-1:0]    cnt_q, cnt_d;
  logic [MW-1:0]    n_q, n_d;
  logic [OUT_W-1:0] partial_q, partial_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
`ifdef CONV_FLUSH_EN
  logic [MW-1:0]    out_count_q, out_count_d;
  logic             flush_fire;
`endif

  logic [MW-1:0]    mode_cl;
  logic [MW-1:0]    n_req;
  logic [MW-1:0]    n_cur;
  logic [MW-1:0]    cnt_inc;
  logic [MW-1:0]    held_cnt;
  logic             accept;
  logic             word_full;
  logic             emit;
  logic [OUT_W-1:0] merged;

  // Upstream may push whenever enabled, out of reset and the output slot can drain.
  assign in_ready = ENB && !RESET && !(out_valid_q && !out_ready);
  assign accept   = in_valid && in_ready;

  // Word-size selection: MODE is clamped, and only consulted at a word boundary.
  always_comb begin
    mode_cl = (MODE > MW'(LG)) ? MW'(LG) : MODE;
    n_req   = MW'(1) << mode_cl;
    n_cur   = (cnt_q == '0) ? n_req : n_q;
  end

  // Datapath: symbols held after this cycle and the merged word candidate.
  always_comb begin
    cnt_inc   = cnt_q + MW'(1);
    held_cnt  = accept ? cnt_inc : cnt_q;
    merged    = accept ? ((partial_q << DATA_W) | OUT_W'(in_data)) : partial_q;
    word_full = accept && (cnt_inc == n_cur);
  end

`ifdef CONV_FLUSH_EN
  // A flush only acts when the slot can take a word and something is held.
  assign flush_fire = flush && in_ready && (held_cnt != '0);
  assign emit       = word_full || flush_fire;
`else
  assign emit       = word_full;
`endif

  // Next-state: ENB low clears everything; completion wins over output drain.
  always_comb begin
    cnt_d       = cnt_q;
    n_d         = n_q;
    partial_d   = partial_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
`ifdef CONV_FLUSH_EN
    out_count_d = out_count_q;
`endif
    if (!ENB) begin
      cnt_d       = '0;
      partial_d   = '0;
      out_valid_d = 1'b0;
      out_data_d  = '0;
`ifdef CONV_FLUSH_EN
      out_count_d = '0;
`endif
    end else begin
      if (out_valid_q && out_ready) begin
        out_valid_d = 1'b0;
      end
      if (accept && (cnt_q == '0)) begin
        n_d = n_req;
      end
      if (emit) begin
        out_valid_d = 1'b1;
        out_data_d  = merged;
        cnt_d       = '0;
        partial_d   = '0;
`ifdef CONV_FLUSH_EN
        out_count_d = held_cnt;
`endif
      end else if (accept) begin
        partial_d = merged;
        cnt_d     = cnt_inc;
      end
    end
  end

  // State registers with synchronous reset taking priority over all other inputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q       <= '0;
      n_q         <= MW'(LANES);
      partial_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
`ifdef CONV_FLUSH_EN
      out_count_q <= '0;
`endif
    end else begin
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      partial_q   <= partial_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
`ifdef CONV_FLUSH_EN
      out_count_q <= out_count_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
`ifdef CONV_FLUSH_EN
  assign out_count = out_count_q;
`endif

endmodule

// File: tb/tb_convertidor_param.sv
// Testbench for convertidor_param (DATA_W=8, LANES=4): directed vectors plus random traffic
// checked against a symbol-queue reference model. Flush paths are exercised when
// CONV_FLUSH_EN is defined.
module tb_convertidor_param;

  localparam int DATA_W = 8;
  localparam int LANES  = 4;
  localparam int OUT_W  = 32;

  logic              CLK = 1'b0;
  logic              RESET;
  logic              ENB;
  logic [2:0]        MODE;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_ready;
`ifdef CONV_FLUSH_EN
  logic              flush;
  logic [2:0]        out_count;
`endif

  always #5 CLK = ~CLK;

  convertidor_param #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .ENB       (ENB),
    .MODE      (MODE),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
`ifdef CONV_FLUSH_EN
    ,
    .flush     (flush),
    .out_count (out_count)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: symbols of the word in progress, its size, and the output slot.
  byte unsigned m_cur[$];
  int           m_n     = LANES;
  bit           m_pend  = 1'b0;
  logic [31:0]  m_data  = '0;
  int           m_count = 0;

  function automatic logic [31:0] pack_word();
    logic [31:0] w;
    int s;
    w = '0;
    s = m_cur.size();
    for (int k = 0; k < s; k++)
      w = w + 32'(m_cur[k]) * (32'd1 << (8 * (s - 1 - k)));
    return w;
  endfunction

  // One clock: check in_ready with inputs settled, advance the model, check outputs after the edge.
  task automatic step();
    bit exp_rdy;
    bit acc;
    bit fl;
    int m;
    #1;
    exp_rdy = ENB && !RESET && !(m_pend && !out_ready);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (RESET) begin
      m_pend = 0; m_data = '0; m_cur.delete(); m_n = LANES; m_count = 0;
    end else if (!ENB) begin
      m_pend = 0; m_data = '0; m_cur.delete(); m_count = 0;
    end else begin
      acc = in_valid && exp_rdy;
      if (m_pend && out_ready) m_pend = 0;
      if (acc) begin
        if (m_cur.size() == 0) begin
          m = (MODE > 3'd2) ? 2 : int'(MODE);
          m_n = 1 << m;
        end
        m_cur.push_back(in_data);
      end
      fl = 1'b0;
`ifdef CONV_FLUSH_EN
      fl = flush && exp_rdy && (m_cur.size() > 0);
`endif
      if ((m_cur.size() == m_n) || fl) begin
        m_data  = pack_word();
        m_pend  = 1;
        m_count = m_cur.size();
        m_cur.delete();
      end
    end
    @(posedge CLK);
    #1;
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_pend});
    chk("out_data", {32'd0, out_data}, {32'd0, m_data});
`ifdef CONV_FLUSH_EN
    chk("out_count", {61'd0, out_count}, 64'(m_count));
`endif
  endtask

  task automatic put(input bit v, input logic [7:0] d, input bit ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    step();
  endtask

  initial begin
    RESET = 1'b1; ENB = 1'b1; MODE = 3'd2;
    in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
`ifdef CONV_FLUSH_EN
    flush = 1'b0;
`endif
    @(posedge CLK); #1;

    // Reset held two cycles with traffic offered.
    step();
    step();
    chk("rst_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_data", {32'd0, out_data}, 64'd0);
    RESET = 1'b0;

    // Full 4-symbol words, back to back.
    MODE = 3'd2;
    put(1, 8'hA1, 1); put(1, 8'hB2, 1); put(1, 8'hC3, 1); put(1, 8'hD4, 1);
    chk("word4", {32'd0, out_data}, 64'hA1B2C3D4);
    put(1, 8'hE5, 1); put(1, 8'hF6, 1); put(1, 8'h07, 1); put(1, 8'h18, 1);
    chk("word4_next", {32'd0, out_data}, 64'hE5F60718);

    // Two-symbol words.
    MODE = 3'd1;
    put(1, 8'h11, 1); put(1, 8'h22, 1);
    chk("word2_a", {32'd0, out_data}, 64'h00001122);
    put(1, 8'h33, 1); put(1, 8'h44, 1);
    chk("word2_b", {32'd0, out_data}, 64'h00003344);

    // Single-symbol words: out_valid stays high.
    MODE = 3'd0;
    for (int i = 0; i < 3; i++) begin
      put(1, 8'h5A, 1);
      chk("word1_vld", {63'd0, out_valid}, 64'd1);
      chk("word1_dat", {32'd0, out_data}, 64'h0000005A);
    end

    // Backpressure: pending word is held, input stalled.
    MODE = 3'd2;
    put(1, 8'hA1, 1); put(1, 8'hB2, 1); put(1, 8'hC3, 1); put(1, 8'hD4, 1);
    for (int i = 0; i < 3; i++) begin
      put(1, 8'h77, 0);
      chk("bp_hold", {32'd0, out_data}, 64'hA1B2C3D4);
    end
    put(1, 8'h11, 1);
    put(1, 8'h22, 1); put(1, 8'h33, 1); put(1, 8'h44, 1);
    chk("bp_resume", {32'd0, out_data}, 64'h11223344);

    // Mode change mid-word is deferred to the next word.
    MODE = 3'd2;
    put(1, 8'h01, 1); put(1, 8'h02, 1);
    MODE = 3'd1;
    put(1, 8'h03, 1); put(1, 8'h04, 1);
    chk("mode_mid", {32'd0, out_data}, 64'h01020304);
    put(1, 8'h05, 1); put(1, 8'h06, 1);
    chk("mode_next", {32'd0, out_data}, 64'h00000506);

    // ENB drop discards a partial word.
    MODE = 3'd2;
    put(1, 8'h10, 1); put(1, 8'h20, 1);
    ENB = 1'b0;
    put(1, 8'h30, 1);
    chk("enb_vld", {63'd0, out_valid}, 64'd0);
    ENB = 1'b1;
    put(1, 8'h0A, 1); put(1, 8'h0B, 1); put(1, 8'h0C, 1); put(1, 8'h0D, 1);
    chk("enb_word", {32'd0, out_data}, 64'h0A0B0C0D);

`ifdef CONV_FLUSH_EN
    // Flush of a three-symbol partial word.
    put(1, 8'hAA, 1); put(1, 8'hBB, 1); put(1, 8'hCC, 1);
    flush = 1'b1;
    put(0, 8'h00, 1);
    flush = 1'b0;
    chk("flush_dat", {32'd0, out_data}, 64'h00AABBCC);
    chk("flush_cnt", {61'd0, out_count}, 64'd3);
    put(0, 8'h00, 1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      RESET     = ($urandom_range(0, 199) == 0);
      ENB       = ($urandom_range(0, 29) != 0);
      MODE      = 3'($urandom_range(0, 7));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
`ifdef CONV_FLUSH_EN
      flush     = ($urandom_range(0, 9) == 0);
`endif
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
